// File: rtl/pkt_fifo_sf.sv
// Store-and-forward AXI-Stream packet FIFO with whole-packet tail drop.
// Only committed, error-free packets are released downstream.
module pkt_fifo_sf #(
  parameter int C_MAX_DEPTH_BITS = 6,
  parameter int C_DATA_WIDTH     = 8,
  parameter int C_MTY_WIDTH      = 8,
  parameter int C_CNT_WIDTH      = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        s_axis_tvalid,
  input  logic [C_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                        s_axis_tlast,
  input  logic [C_MTY_WIDTH-1:0]      s_axis_tuser_mty,
  input  logic                        s_axis_tuser_err,
  output logic                        s_axis_tready,
  output logic                        m_axis_tvalid,
  output logic [C_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic [C_MTY_WIDTH-1:0]      m_axis_tuser_mty,
  input  logic                        m_axis_tready,
  output logic [C_MAX_DEPTH_BITS:0]   pkt_cnt,
  output logic [C_MAX_DEPTH_BITS:0]   fill_level,
  output logic [C_CNT_WIDTH-1:0]      drop_ovf_cnt,
  output logic [C_CNT_WIDTH-1:0]      drop_err_cnt
);

  localparam int AW    = C_MAX_DEPTH_BITS;
  localparam int PW    = C_MAX_DEPTH_BITS + 1;
  localparam int DEPTH = 1 << C_MAX_DEPTH_BITS;
  localparam int EW    = C_DATA_WIDTH + C_MTY_WIDTH + 1;

  typedef enum logic {
    WR_PASS = 1'b0,
    WR_DROP = 1'b1
  } wr_st_e;

  wr_st_e r_st;
  wr_st_e w_st_nxt;

  logic [PW-1:0] r_wr_p;
  logic [PW-1:0] r_commit_p;
  logic [PW-1:0] r_rd_p;
  logic          r_rdy;

  logic [EW-1:0] r_mem [DEPTH];
  logic [EW-1:0] r_ram_q;
  logic          r_rd_en_d;

  logic [EW-1:0] r_q0;
  logic [EW-1:0] r_q1;
  logic [1:0]    r_qcnt;

  logic [PW-1:0]          r_pkt_cnt;
  logic [C_CNT_WIDTH-1:0] r_ovf_cnt;
  logic [C_CNT_WIDTH-1:0] r_err_cnt;

  logic          w_beat;
  logic [PW-1:0] w_used;
  logic          w_full;
  logic          w_we;
  logic          w_commit;
  logic          w_drop_ovf;
  logic          w_drop_err;
  logic [PW-1:0] w_wr_p_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [1:0]    w_occ;
  logic          w_out_last;

  assign w_beat = s_axis_tvalid & r_rdy;
  assign w_used = r_wr_p - r_rd_p;
  assign w_full = (w_used == PW'(DEPTH));

  // Input is always accepted once out of reset; overflow is handled by dropping
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rdy <= 1'b0;
    else          r_rdy <= 1'b1;
  end

  // Write FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_st <= WR_PASS;
    else          r_st <= w_st_nxt;
  end

  // Write FSM next state: leave PASS when a non-last beat hits a full buffer
  always_comb begin
    w_st_nxt = r_st;
    if (w_beat) begin
      unique case (r_st)
        WR_PASS: if (w_full && !s_axis_tlast) w_st_nxt = WR_DROP;
        WR_DROP: if (s_axis_tlast)            w_st_nxt = WR_PASS;
      endcase
    end
  end

  // Write FSM outputs: store, commit, or rewind to the last commit point
  always_comb begin
    w_we       = 1'b0;
    w_commit   = 1'b0;
    w_drop_ovf = 1'b0;
    w_drop_err = 1'b0;
    w_wr_p_nxt = r_wr_p;
    if (w_beat) begin
      unique case (r_st)
        WR_PASS: begin
          if (w_full) begin
            w_wr_p_nxt = r_commit_p;
            w_drop_ovf = s_axis_tlast;
          end else begin
            w_we       = 1'b1;
            w_wr_p_nxt = r_wr_p + PW'(1);
            if (s_axis_tlast && s_axis_tuser_err) begin
              w_wr_p_nxt = r_commit_p;
              w_drop_err = 1'b1;
            end else if (s_axis_tlast) begin
              w_commit = 1'b1;
            end
          end
        end
        WR_DROP: w_drop_ovf = s_axis_tlast;
      endcase
    end
  end

  // Write and commit pointers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_p     <= '0;
      r_commit_p <= '0;
    end else begin
      r_wr_p <= w_wr_p_nxt;
      if (w_commit) r_commit_p <= r_wr_p + PW'(1);
    end
  end

  // Simple dual-port RAM, registered read; contents need no reset
  always_ff @(posedge aclk) begin
    if (w_we)
      r_mem[r_wr_p[AW-1:0]] <= {s_axis_tlast, s_axis_tuser_mty, s_axis_tdata};
    if (w_issue)
      r_ram_q <= r_mem[r_rd_p[AW-1:0]];
  end

  // Prefetch: keep at most two beats held or in flight ahead of the consumer
  assign w_pop   = (r_qcnt != 2'd0) & m_axis_tready;
  assign w_push  = r_rd_en_d;
  assign w_occ   = r_qcnt + {1'b0, r_rd_en_d};
  assign w_issue = (r_rd_p != r_commit_p) & ((w_occ != 2'd2) | w_pop);

  // Read pointer and read-in-flight flag
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_p    <= '0;
      r_rd_en_d <= 1'b0;
    end else begin
      if (w_issue) r_rd_p <= r_rd_p + PW'(1);
      r_rd_en_d <= w_issue;
    end
  end

  // Two-entry output queue; head entry drives the master port
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_q0   <= '0;
      r_q1   <= '0;
      r_qcnt <= 2'd0;
    end else begin
      if (w_pop) begin
        if (w_push)                r_q0 <= r_ram_q;
        else if (r_qcnt == 2'd2)   r_q0 <= r_q1;
      end else if (w_push) begin
        if (r_qcnt == 2'd0) r_q0 <= r_ram_q;
        else                r_q1 <= r_ram_q;
      end
      r_qcnt <= r_qcnt - {1'b0, w_pop} + {1'b0, w_push};
    end
  end

  assign w_out_last = r_q0[EW-1];

  // Committed-but-unsent packet count
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pkt_cnt <= '0;
    end else begin
      unique case ({w_commit, w_pop & w_out_last})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + PW'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - PW'(1);
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
    end
  end

  // Saturating drop counters
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ovf_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_drop_ovf && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + 1'b1;
      if (w_drop_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign s_axis_tready    = r_rdy;
  assign m_axis_tvalid    = (r_qcnt != 2'd0);
  assign m_axis_tlast     = r_q0[EW-1];
  assign m_axis_tuser_mty = r_q0[EW-2 -: C_MTY_WIDTH];
  assign m_axis_tdata     = r_q0[C_DATA_WIDTH-1:0];
  assign pkt_cnt          = r_pkt_cnt;
  assign fill_level       = w_used;
  assign drop_ovf_cnt     = r_ovf_cnt;
  assign drop_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_pkt_fifo_sf.sv
// Bench for pkt_fifo_sf: packet-level model with queues,
// per-cycle output compare, directed corner cases and random traffic.
module tb_pkt_fifo_sf;

  localparam int DEPTH = 64;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tlast = 1'b0;
  logic [7:0]  s_axis_tuser_mty = '0;
  logic        s_axis_tuser_err = 1'b0;
  logic        s_axis_tready;
  logic        m_axis_tvalid;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tuser_mty;
  logic        m_axis_tready = 1'b0;
  logic [6:0]  pkt_cnt;
  logic [6:0]  fill_level;
  logic [31:0] drop_ovf_cnt;
  logic [31:0] drop_err_cnt;

  always #5 aclk = ~aclk;

  pkt_fifo_sf dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tuser_mty (s_axis_tuser_mty),
    .s_axis_tuser_err (s_axis_tuser_err),
    .s_axis_tready    (s_axis_tready),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser_mty (m_axis_tuser_mty),
    .m_axis_tready    (m_axis_tready),
    .pkt_cnt          (pkt_cnt),
    .fill_level       (fill_level),
    .drop_ovf_cnt     (drop_ovf_cnt),
    .drop_err_cnt     (drop_err_cnt)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [7:0] m;
  } beat_t;

  int n_chk = 0;
  int n_err = 0;

  // model state owned by the stimulus process
  beat_t exp_arr[$];
  beat_t cur[$];
  bit    m_drop = 1'b0;
  int    m_commits = 0;
  int    m_ovf = 0;
  int    m_err = 0;

  // state owned by the compare process
  int         mon_idx = 0;
  int         m_tl_done = 0;
  bit         in_pkt = 1'b0;
  bit         hold_prev = 1'b0;
  logic [16:0] prev_bus = '0;
  logic [7:0] obs[$];
  logic [7:0] obs_mty = '0;

  bit chk_en = 1'b0;
  int rdy_mode = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int outstanding();
    return exp_arr.size() - mon_idx;
  endfunction

  // packet-level reference: whole packets kept, overflow/err packets vanish
  task automatic model_beat(input logic [7:0] d, input bit l,
                            input logic [7:0] m, input bit e);
    beat_t b;
    b.d = d;
    b.l = l;
    b.m = m;
    if (m_drop) begin
      if (l) begin
        m_ovf++;
        m_drop = 1'b0;
      end
    end else if (cur.size() + outstanding() >= DEPTH) begin
      cur.delete();
      if (l) m_ovf++;
      else   m_drop = 1'b1;
    end else begin
      cur.push_back(b);
      if (l) begin
        if (e) begin
          m_err++;
        end else begin
          foreach (cur[i]) exp_arr.push_back(cur[i]);
          m_commits++;
        end
        cur.delete();
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input bit l,
                           input logic [7:0] m, input bit e);
    bit acc;
    s_axis_tvalid    = 1'b1;
    s_axis_tdata     = d;
    s_axis_tlast     = l;
    s_axis_tuser_mty = m;
    s_axis_tuser_err = e;
    acc = s_axis_tready;
    @(posedge aclk);
    if (acc) model_beat(d, l, m, e);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit err, input int gapmax);
    int w;
    w = 0;
    while ((outstanding() + len > DEPTH - 1) && (w < 5000)) begin
      idle(1);
      w++;
    end
    if (w >= 5000) chk("gate_wait_timeout", w, 0);
    for (int i = 0; i < len; i++) begin
      send_beat(8'($urandom), (i == len - 1), 8'($urandom),
                err && (i == len - 1));
      if (gapmax > 0 && $urandom_range(0, 3) == 0)
        idle($urandom_range(1, gapmax));
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    rdy_mode = 0;
    while ((outstanding() != 0 || m_axis_tvalid) && w < 3000) begin
      idle(1);
      w++;
    end
    if (w >= 3000) chk("drain_timeout", w, 0);
    idle(2);
  endtask

  task automatic lat_chk(input string nm);
    int n;
    for (n = 1; n <= 6; n++) begin
      @(negedge aclk);
      if (m_axis_tvalid) break;
    end
    chk(nm, n, 3);
  endtask

  // downstream ready pattern
  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      2:       m_axis_tready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // per-cycle compare against the model
  always @(negedge aclk) begin
    beat_t e;
    if (!chk_en) begin
      in_pkt    = 1'b0;
      hold_prev = 1'b0;
      mon_idx   = exp_arr.size();
      m_tl_done = m_commits;
    end else begin
      chk("pkt_cnt", pkt_cnt, m_commits - m_tl_done);
      chk("drop_ovf_cnt", drop_ovf_cnt, m_ovf);
      chk("drop_err_cnt", drop_err_cnt, m_err);
      chk("s_axis_tready", s_axis_tready, 1);
      if (in_pkt) chk("gap_in_packet", m_axis_tvalid, 1);
      if (hold_prev) begin
        chk("hold_tvalid", m_axis_tvalid, 1);
        chk("hold_bus", {m_axis_tlast, m_axis_tuser_mty, m_axis_tdata},
            prev_bus);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (mon_idx >= exp_arr.size()) begin
          chk("unexpected_beat", m_axis_tdata, -1);
        end else begin
          e = exp_arr[mon_idx];
          mon_idx++;
          chk("tdata", m_axis_tdata, e.d);
          chk("tlast", m_axis_tlast, e.l);
          if (e.l) chk("tuser_mty", m_axis_tuser_mty, e.m);
        end
        obs.push_back(m_axis_tdata);
        if (m_axis_tlast) begin
          obs_mty = m_axis_tuser_mty;
          m_tl_done++;
        end
        in_pkt = !m_axis_tlast;
      end
      hold_prev = m_axis_tvalid && !m_axis_tready;
      prev_bus  = {m_axis_tlast, m_axis_tuser_mty, m_axis_tdata};
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int w;

    // reset state
    @(posedge aclk);
    #1;
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_ovf", drop_ovf_cnt, 0);
    idle(2);
    aresetn = 1'b1;
    idle(2);
    chk_en = 1'b1;

    // T1: 3-beat packet, latency and content
    s = obs.size();
    send_beat(8'h11, 0, 8'h0, 0);
    send_beat(8'h22, 0, 8'h0, 0);
    send_beat(8'h33, 1, 8'h5, 0);
    lat_chk("T1_latency");
    chk("T1_pkt_cnt_1", pkt_cnt, 1);
    drain();
    chk("T1_nbeats", obs.size() - s, 3);
    chk("T1_b0", obs[s], 8'h11);
    chk("T1_b1", obs[s+1], 8'h22);
    chk("T1_b2", obs[s+2], 8'h33);
    chk("T1_mty", obs_mty, 5);
    chk("T1_pkt_cnt_0", pkt_cnt, 0);

    // T2: overflow drop (70 beats), full-on-tlast (65), exact fit (64)
    s = obs.size();
    for (int i = 0; i < 70; i++) begin
      send_beat(8'(i), (i == 69), 8'h0, 0);
      if (i == 63) chk("T2_fill_full", fill_level, 64);
    end
    send_pkt(4, 0, 0);
    drain();
    chk("T2_ovf", drop_ovf_cnt, 1);
    chk("T2_nbeats", obs.size() - s, 4);
    chk("T2_fill0", fill_level, 0);
    s = obs.size();
    for (int i = 0; i < 65; i++)
      send_beat(8'(i), (i == 64), 8'h0, 0);
    drain();
    chk("T2_ovf_last", drop_ovf_cnt, 2);
    chk("T2_nbeats_65", obs.size() - s, 0);
    for (int i = 0; i < 64; i++)
      send_beat(8'(i), (i == 63), 8'h0, 0);
    drain();
    chk("T2_fit64", obs.size() - s, 64);
    chk("T2_fill0b", fill_level, 0);

    // T3: err packet dropped, clean packet passes
    s = obs.size();
    send_beat(8'hA1, 0, 8'h0, 0);
    send_beat(8'hA2, 1, 8'h0, 1);
    send_beat(8'hB1, 0, 8'h0, 0);
    send_beat(8'hB2, 1, 8'h1, 0);
    drain();
    chk("T3_err", drop_err_cnt, 1);
    chk("T3_nbeats", obs.size() - s, 2);
    chk("T3_b0", obs[s], 8'hB1);
    chk("T3_b1", obs[s+1], 8'hB2);

    // T4: toggling ready, 10 back-to-back 8-beat packets
    s = obs.size();
    rdy_mode = 1;
    for (int p = 0; p < 10; p++) send_pkt(8, 0, 0);
    drain();
    chk("T4_nbeats", obs.size() - s, 80);

    // T5: commit and output tlast in the same clock
    rdy_mode = 3;
    m_axis_tready = 1'b0;
    send_beat(8'hA5, 1, 8'h1, 0);
    w = 0;
    while (!m_axis_tvalid && w < 10) begin
      idle(1);
      w++;
    end
    chk("T5_valid", m_axis_tvalid, 1);
    m_axis_tready = 1'b1;
    send_beat(8'hC3, 1, 8'h2, 0);
    chk("T5_pkt_cnt_same_clk", pkt_cnt, 1);
    drain();

    // random traffic, wraps pointers many times
    rdy_mode = 2;
    for (int p = 0; p < 200; p++)
      send_pkt($urandom_range(1, 12), ($urandom_range(0, 7) == 0), 3);
    drain();
    chk("rand_fill0", fill_level, 0);

    // T6: reset mid-packet on both sides
    rdy_mode = 3;
    m_axis_tready = 1'b0;
    send_beat(8'h77, 1, 8'h0, 0);
    idle(4);
    send_beat(8'h01, 0, 8'h0, 0);
    send_beat(8'h02, 0, 8'h0, 0);
    chk_en = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("T6_tvalid", m_axis_tvalid, 0);
    chk("T6_tdata", m_axis_tdata, 0);
    chk("T6_tlast", m_axis_tlast, 0);
    chk("T6_mty", m_axis_tuser_mty, 0);
    chk("T6_pkt_cnt", pkt_cnt, 0);
    chk("T6_fill", fill_level, 0);
    chk("T6_s_tready", s_axis_tready, 0);
    chk("T6_ovf", drop_ovf_cnt, 0);
    chk("T6_err", drop_err_cnt, 0);
    cur.delete();
    m_drop = 1'b0;
    m_ovf = 0;
    m_err = 0;
    @(posedge aclk);
    #1;
    idle(2);
    aresetn = 1'b1;
    idle(2);
    rdy_mode = 0;
    chk_en = 1'b1;
    idle(1);
    s = obs.size();
    send_beat(8'h5A, 1, 8'h3, 0);
    lat_chk("T6_latency");
    drain();
    chk("T6_nbeats", obs.size() - s, 1);
    chk("T6_data", obs[s], 8'h5A);
    chk("T6_fill0", fill_level, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
